// File: rtl/pitch_classifier.sv
`timescale 1ns/1ps
// Guitar string classifier: averages four input periods, picks the nearest open
// string and reports flat/sharp/in-tune in 7-segment decoder codes.
module pitch_classifier #(
    parameter int P_E2       = 606722,
    parameter int P_A2       = 454545,
    parameter int P_D3       = 340530,
    parameter int P_G3       = 255102,
    parameter int P_B3       = 202478,
    parameter int P_E4       = 151685,
    parameter int MIN_PERIOD = 100000,
    parameter int TIMEOUT    = 1000000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       sig_in,
    output logic [3:0] note_code,
    output logic [3:0] tune_code,
    output logic       no_signal,
    output logic       out_valid
);

    typedef enum logic [1:0] {IDLE, MEASURE, CLASSIFY, JUDGE} state_t;

    state_t      state, state_next;
    logic        sync1, sync2, sync3, edge_det;
    logic [19:0] count;
    logic [21:0] acc;
    logic [21:0] acc_sum;
    logic [1:0]  pidx;
    logic [19:0] avg_period;
    logic [2:0]  cls_idx;
    logic [2:0]  best_idx;
    logic [19:0] best_dist;

    logic        timeout, edge_valid, batch_done, last_cls, judge_fire;
    logic [19:0] cls_dist;
    logic        cls_better;
    logic [2:0]  final_idx;
    logic [19:0] p_best, tol, p_lo;
    logic [20:0] p_hi;
    logic [3:0]  judge_tune;

    function automatic logic [19:0] period_of(input logic [2:0] i);
        case (i)
            3'd0:    period_of = 20'(P_E2);
            3'd1:    period_of = 20'(P_A2);
            3'd2:    period_of = 20'(P_D3);
            3'd3:    period_of = 20'(P_G3);
            3'd4:    period_of = 20'(P_B3);
            default: period_of = 20'(P_E4);
        endcase
    endfunction

    function automatic logic [19:0] abs_diff(input logic [19:0] a, input logic [19:0] b);
        abs_diff = (a >= b) ? (a - b) : (b - a);
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            sync3    <= 1'b0;
            edge_det <= 1'b0;
        end else begin
            sync1    <= sig_in;
            sync2    <= sync1;
            sync3    <= sync2;
            edge_det <= sync2 & ~sync3;
        end
    end

    assign timeout    = (state != IDLE) && (count >= 20'(TIMEOUT));
    assign edge_valid = edge_det && (state != IDLE) && (count >= 20'(MIN_PERIOD)) && !timeout;
    assign batch_done = edge_valid && (pidx == 2'd3);
    assign acc_sum    = acc + {2'b00, count};
    assign last_cls   = (state == CLASSIFY) && (cls_idx == 3'd5);

    // The last comparison is folded into the judgement so the result lands as JUDGE begins.
    assign cls_dist   = abs_diff(avg_period, period_of(cls_idx));
    assign cls_better = (cls_idx == 3'd0) || (cls_dist < best_dist);
    assign final_idx  = cls_better ? cls_idx : best_idx;
    assign p_best     = period_of(final_idx);
    assign tol        = p_best >> 7;
    assign p_hi       = {1'b0, p_best} + {1'b0, tol};
    assign p_lo       = p_best - tol;
    assign judge_tune = ({1'b0, avg_period} > p_hi) ? 4'h6 :
                        (avg_period < p_lo)         ? 4'h7 : 4'hE;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        judge_fire = 1'b0;
        case (state)
            IDLE:     if (edge_det) state_next = MEASURE;
            MEASURE:  if (batch_done) state_next = CLASSIFY;
            CLASSIFY: begin
                if (batch_done) begin
                    state_next = CLASSIFY;
                end else if (last_cls) begin
                    state_next = JUDGE;
                    judge_fire = 1'b1;
                end
            end
            JUDGE:    state_next = batch_done ? CLASSIFY : MEASURE;
            default:  state_next = IDLE;
        endcase
        if (timeout) begin
            state_next = IDLE;
            judge_fire = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count      <= '0;
            acc        <= '0;
            pidx       <= '0;
            avg_period <= '0;
            cls_idx    <= '0;
            best_idx   <= '0;
            best_dist  <= '0;
        end else begin
            if (timeout) begin
                count <= '0;
                acc   <= '0;
                pidx  <= '0;
            end else if (state == IDLE) begin
                if (edge_det) count <= 20'd1;
            end else if (edge_valid) begin
                count <= 20'd1;
                if (pidx == 2'd3) begin
                    avg_period <= acc_sum[21:2];
                    acc        <= '0;
                    pidx       <= '0;
                end else begin
                    acc  <= acc_sum;
                    pidx <= pidx + 2'd1;
                end
            end else begin
                count <= count + 20'd1;
            end

            if (batch_done) begin
                cls_idx <= '0;
            end else if (state == CLASSIFY) begin
                cls_idx   <= cls_idx + 3'd1;
                best_idx  <= final_idx;
                best_dist <= cls_better ? cls_dist : best_dist;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            note_code <= 4'hF;
            tune_code <= 4'hF;
            no_signal <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (timeout) begin
                note_code <= 4'hF;
                tune_code <= 4'hF;
                no_signal <= 1'b1;
                out_valid <= 1'b1;
            end else if (judge_fire) begin
                note_code <= {1'b0, final_idx};
                tune_code <= judge_tune;
                no_signal <= 1'b0;
                out_valid <= 1'b1;
            end
        end
    end

endmodule
